// File: rtl/pulse_capture_ctrl.sv
// pulse_capture_ctrl: ring-buffered pre/post-trigger capture of multi-channel frames,
// triggered by a run of over-threshold frames and streamed out word by word.
module pulse_capture_ctrl #(
  parameter int DATA_W       = 16,
  parameter int NUM_CH       = 4,
  parameter int DEPTH        = 1024,
  parameter int PRE_SAMPLES  = 500,
  parameter int POST_SAMPLES = 500,
  parameter int THRESH       = 32,
  parameter int VALID_RUN    = 20,
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arm,
  input  logic [NUM_CH-1:0]        ch_mask,
  input  logic                     trig_all,
  input  logic                     s_valid,
  input  logic [NUM_CH*DATA_W-1:0] s_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DATA_W-1:0]        m_data,
  output logic [CW-1:0]            m_ch,
  output logic                     m_last,
  output logic                     busy,
  output logic                     trig,
  output logic [LW-1:0]            cap_len,
  output logic [15:0]              drop_cnt
);
  localparam int RW = $clog2(VALID_RUN + 1);
  localparam logic [DATA_W:0] THR = (DATA_W+1)'(THRESH);
  localparam logic [CW-1:0] LAST_CH = CW'(NUM_CH - 1);
  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_POST, S_READOUT} state_t;
  state_t state_q;
  logic [NUM_CH*DATA_W-1:0] mem [DEPTH];
  logic [NUM_CH*DATA_W-1:0] frame_q;
  logic [AW-1:0] wr_q, rd_q;
  logic [LW-1:0] pre_q, post_q, left_q, cap_q;
  logic [RW-1:0] run_q;
  logic [CW-1:0] ch_q, m_ch_q;
  logic [DATA_W-1:0] m_data_q;
  logic [15:0] drop_q;
  logic rv_q, lastf_q, m_valid_q, m_last_q, busy_q, trig_q;
  logic [NUM_CH-1:0] qual;
  logic frame_ok, run_hit, we, ld, adv, fdone, hs_last;
  genvar c;
  for (c = 0; c < NUM_CH; c++) begin : g_ch
    logic [DATA_W:0] ext, mag;
    // one extra bit so the most negative code has a representable magnitude
    assign ext = {s_data[c*DATA_W+DATA_W-1], s_data[c*DATA_W +: DATA_W]};
    assign mag = ext[DATA_W] ? -ext : ext;
    assign qual[c] = ch_mask[c] && (mag >= THR);
  end
  assign frame_ok = trig_all ? (|ch_mask && &(qual | ~ch_mask)) : |qual;
  assign run_hit  = frame_ok && (run_q == RW'(VALID_RUN - 1));
  assign we       = s_valid && (state_q == S_ARMED || state_q == S_POST);
  assign adv      = rv_q && (!m_valid_q || m_ready);
  assign fdone    = adv && (ch_q == LAST_CH);
  assign ld       = (state_q == S_READOUT) && (!rv_q || fdone) && (left_q != '0);
  assign hs_last  = m_valid_q && m_ready && m_last_q;
  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign m_ch     = m_ch_q;
  assign m_last   = m_last_q;
  assign busy     = busy_q;
  assign trig     = trig_q;
  assign cap_len  = cap_q;
  assign drop_cnt = drop_q;
  always_ff @(posedge clk) begin
    if (we) mem[wr_q] <= s_data;
    if (ld) frame_q <= mem[rd_q];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      wr_q      <= '0;
      rd_q      <= '0;
      pre_q     <= '0;
      post_q    <= '0;
      left_q    <= '0;
      cap_q     <= '0;
      run_q     <= '0;
      ch_q      <= '0;
      m_ch_q    <= '0;
      m_data_q  <= '0;
      drop_q    <= '0;
      rv_q      <= 1'b0;
      lastf_q   <= 1'b0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      busy_q    <= 1'b0;
      trig_q    <= 1'b0;
    end else begin
      trig_q <= 1'b0;
      if (we) wr_q <= wr_q + 1'b1;
      if (state_q == S_READOUT && s_valid && drop_q != '1) drop_q <= drop_q + 1'b1;
      case (state_q)
        S_IDLE: if (arm) begin
          state_q <= S_ARMED;
          busy_q  <= 1'b1;
          run_q   <= '0;
          pre_q   <= '0;
        end
        S_ARMED: if (s_valid) begin
          if (run_hit) begin
            trig_q  <= 1'b1;
            cap_q   <= pre_q + LW'(POST_SAMPLES);
            left_q  <= pre_q + LW'(POST_SAMPLES);
            rd_q    <= wr_q - pre_q[AW-1:0];
            post_q  <= LW'(1);
            state_q <= (POST_SAMPLES == 1) ? S_READOUT : S_POST;
          end else begin
            run_q <= frame_ok ? run_q + 1'b1 : '0;
            if (pre_q < LW'(PRE_SAMPLES)) pre_q <= pre_q + 1'b1;
          end
        end
        S_POST: if (s_valid) begin
          post_q <= post_q + 1'b1;
          if (post_q == LW'(POST_SAMPLES - 1)) state_q <= S_READOUT;
        end
        S_READOUT: if (hs_last) begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
      // frame register refills on the same cycle its last channel moves to the output
      if (ld) begin
        rv_q    <= 1'b1;
        rd_q    <= rd_q + 1'b1;
        left_q  <= left_q - 1'b1;
        lastf_q <= (left_q == LW'(1));
      end else if (fdone) begin
        rv_q <= 1'b0;
      end
      if (adv) begin
        m_valid_q <= 1'b1;
        m_data_q  <= frame_q[ch_q*DATA_W +: DATA_W];
        m_ch_q    <= ch_q;
        m_last_q  <= lastf_q && (ch_q == LAST_CH);
        ch_q      <= (ch_q == LAST_CH) ? '0 : ch_q + 1'b1;
      end else if (m_ready) begin
        m_valid_q <= 1'b0;
        m_last_q  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_pulse_capture_ctrl.sv
// tb_pulse_capture_ctrl: directed captures with a scoreboard queue checked by a readout monitor.
module tb_pulse_capture_ctrl;
  typedef struct {logic [15:0] d; logic [1:0] ch; logic last;} exp_t;
  logic clk = 0, rst = 0, arm = 0, trig_all = 0, s_valid = 0, m_ready = 1;
  logic [3:0] ch_mask = 4'b0001;
  logic [63:0] s_data = '0;
  logic m_valid, m_last, busy, trig;
  logic [15:0] m_data, drop_cnt;
  logic [1:0] m_ch;
  logic [10:0] cap_len;
  int checks = 0, fails = 0;
  exp_t q[$];
  logic [63:0] sent[$];
  int frame_n = 0, trig_at = 0;
  bit bp = 0;

  pulse_capture_ctrl dut (
    .clk(clk), .rst(rst), .arm(arm), .ch_mask(ch_mask), .trig_all(trig_all),
    .s_valid(s_valid), .s_data(s_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_ch(m_ch), .m_last(m_last), .busy(busy), .trig(trig),
    .cap_len(cap_len), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", n, a, e);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    m_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  logic stall = 0, pl = 0, chk_busy = 0;
  logic [15:0] pd = '0;
  logic [1:0] pc = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      stall = 0;
      chk_busy = 0;
    end else begin
      if (chk_busy) begin
        chk("busy_after_last", busy, 0);
        chk_busy = 0;
      end
      if (stall) begin
        checks++;
        if (!m_valid || m_data !== pd || m_ch !== pc || m_last !== pl) begin
          fails++;
          $display("FAIL stall_stable got v=%b d=%h ch=%0d last=%b exp v=1 d=%h ch=%0d last=%b",
                   m_valid, m_data, m_ch, m_last, pd, pc, pl);
        end
      end
      if (m_valid && m_ready) begin
        checks++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL extra_word got d=%h ch=%0d exp none", m_data, m_ch);
        end else begin
          e = q.pop_front();
          if (m_data !== e.d || m_ch !== e.ch || m_last !== e.last) begin
            fails++;
            $display("FAIL word got d=%h ch=%0d last=%b exp d=%h ch=%0d last=%b",
                     m_data, m_ch, m_last, e.d, e.ch, e.last);
          end
        end
        if (m_last) chk_busy = 1;
      end
      stall = m_valid && !m_ready;
      pd = m_data;
      pc = m_ch;
      pl = m_last;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm;
    sent.delete();
    frame_n = 0;
    trig_at = 0;
    arm = 1;
    tick;
    arm = 0;
  endtask

  // ch2/ch3 carry the frame number so ordering errors are visible
  task automatic sendf(input logic [15:0] c0, input logic [15:0] c1, input int gap);
    logic [15:0] k;
    k = 16'(frame_n + 1);
    s_data = {16'h3000 + k, k ^ 16'hA5A5, c1, c0};
    s_valid = 1;
    tick;
    s_valid = 0;
    sent.push_back(s_data);
    frame_n++;
    if (trig && trig_at == 0) trig_at = frame_n;
    repeat (gap) tick;
  endtask

  task automatic finish_cap(input int t, input int exp_cap, input int gap);
    int pre;
    logic [63:0] f;
    while (frame_n < t + 499) sendf(16'd0, 16'd0, gap);
    chk("trig_frame", 64'(trig_at), 64'(t));
    chk("cap_len", 64'(cap_len), 64'(exp_cap));
    pre = (t - 1 < 500) ? t - 1 : 500;
    for (int i = t - pre; i <= t + 499; i++) begin
      f = sent[i-1];
      for (int c = 0; c < 4; c++)
        q.push_back('{d: 16'(f >> (c * 16)), ch: 2'(c), last: (i == t + 499 && c == 3)});
    end
  endtask

  task automatic wait_done(input int exp_drop);
    int n;
    n = 0;
    while ((q.size() != 0 || busy) && n < 20000) begin
      tick;
      n++;
    end
    if (n >= 20000) begin
      fails++;
      $display("FAIL readout_timeout got pending=%0d exp 0", q.size());
      q.delete();
    end
    chk("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
  endtask

  task automatic chk_reset_outputs;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_trig", trig, 0);
    chk("rst_busy", busy, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_ch", m_ch, 0);
    chk("rst_cap_len", cap_len, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs();
    rst = 1;
    tick;
    // basic capture, driver-rate frames
    do_arm();
    chk("busy_armed", busy, 1);
    repeat (600) sendf(16'd0, 16'd0, 1);
    repeat (25) sendf(16'd100, 16'd0, 1);
    finish_cap(620, 1000, 1);
    wait_done(0);
    // short pre-history, back-to-back, negative samples
    do_arm();
    repeat (20) sendf(16'hFFD8, 16'd0, 0);
    finish_cap(20, 519, 0);
    wait_done(0);
    // run broken by a frame at THRESH-1; 0x8000 must qualify
    do_arm();
    repeat (19) sendf(16'd32, 16'd0, 0);
    sendf(16'd31, 16'd0, 0);
    repeat (20) sendf(16'h8000, 16'd0, 0);
    finish_cap(40, 539, 0);
    wait_done(0);
    // all masked channels must qualify
    ch_mask = 4'b0011;
    trig_all = 1;
    do_arm();
    repeat (30) sendf(16'd100, 16'd0, 0);
    repeat (20) sendf(16'd100, 16'd50, 0);
    finish_cap(50, 549, 0);
    wait_done(0);
    // backpressure plus frames dropped during readout
    ch_mask = 4'b0001;
    trig_all = 0;
    do_arm();
    repeat (5) sendf(16'd0, 16'd0, 0);
    repeat (20) sendf(16'hFFE0, 16'd0, 0);
    finish_cap(25, 524, 0);
    bp = 1;
    repeat (10) sendf(16'd7, 16'd0, 2);
    wait_done(10);
    bp = 0;
    // reset mid-readout, then a fresh capture
    do_arm();
    repeat (20) sendf(16'd100, 16'd0, 0);
    finish_cap(20, 519, 0);
    repeat (300) tick;
    chk("busy_mid_readout", busy, 1);
    rst = 0;
    #1;
    chk_reset_outputs();
    q.delete();
    tick;
    rst = 1;
    tick;
    do_arm();
    repeat (3) sendf(16'd0, 16'd0, 0);
    repeat (20) sendf(16'd100, 16'd0, 0);
    finish_cap(23, 522, 0);
    wait_done(0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
